// File: rtl/arm7_pipe_ctrl.sv
// Fetch/decode/execute sequencer for the ARM7 core: owns the PC, fetches over req/ack,
// handles execute stalls, branch flushes and, with ARM7_COND_EN defined, condition-code squashing.
module arm7_pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        decode_en,
  output logic [31:0] decode_instr,
  output logic        exec_en,
  output logic [31:0] exec_instr,
  output logic [31:0] exec_pc,
  input  logic        exec_busy,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [3:0]  flags,
  output logic [31:0] retired
);

  typedef enum logic {F_RUN, F_DROP} fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
    logic [31:0] pc;
  } slot_t;

  fetch_state_e state_q, state_d;
  slot_t        f_q, d_q, e_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  logic [31:0]  retired_q;

  logic cond_pass;
  logic stall, e_adv, d_adv, f_adv, flush, fetch_take;

`ifdef ARM7_COND_EN
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cond_pass = 1'b0;
    case (e_q.word[31:28])
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic flags_unused;
  assign flags_unused = ^flags;
  assign cond_pass    = 1'b1;
`endif

  // Strobes are forced low while rst is high, independent of the clock.
  assign exec_en    = ~rst & e_q.valid & cond_pass;
  assign stall      = exec_en & exec_busy;
  assign e_adv      = ~stall;
  assign d_adv      = d_q.valid & e_adv;
  assign f_adv      = f_q.valid & (~d_q.valid | d_adv);
  assign flush      = exec_en & ~exec_busy & branch_taken;
  assign fetch_take = (state_q == F_RUN) & imem_req & imem_ack;

  assign decode_en    = ~rst & d_adv;
  assign decode_instr = d_q.word;
  assign exec_instr   = e_q.word;
  assign exec_pc      = e_q.pc;
  assign retired      = retired_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= F_RUN;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      F_RUN:  if (flush && imem_req && !imem_ack) state_d = F_DROP;
      F_DROP: if (imem_ack) state_d = F_RUN;
    endcase
  end

  // A request abandoned by a flush is still completed against its original address.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      F_RUN: begin
        imem_req  = ~f_q.valid | f_adv;
        imem_addr = pc_q;
      end
      F_DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
    endcase
    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      f_q        <= '0;
      d_q        <= '0;
      e_q        <= '0;
      retired_q  <= '0;
    end else begin
      // Tracks the PC while running, so it freezes on the outstanding address when a flush drops it.
      if (state_q == F_RUN) req_addr_q <= pc_q;

      if (flush)           pc_q <= branch_target & 32'hFFFF_FFFC;
      else if (fetch_take) pc_q <= pc_q + 32'd4;

      if (flush)           f_q.valid <= 1'b0;
      else if (fetch_take) f_q <= '{valid: 1'b1, word: imem_rdata, pc: pc_q};
      else if (f_adv)      f_q.valid <= 1'b0;

      if (flush)      d_q.valid <= 1'b0;
      else if (f_adv) d_q <= f_q;
      else if (d_adv) d_q.valid <= 1'b0;

      if (flush)      e_q.valid <= 1'b0;
      else if (d_adv) e_q <= d_q;
      else if (e_adv) e_q.valid <= 1'b0;

      if (exec_en && !exec_busy) retired_q <= retired_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_arm7_pipe_ctrl.sv
// Self-checking bench for arm7_pipe_ctrl: directed pipeline scenarios plus a randomized run
// checked against a program-order model of which addresses must execute.
module tb_arm7_pipe_ctrl;

`ifdef ARM7_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        decode_en;
  logic [31:0] decode_instr;
  logic        exec_en;
  logic [31:0] exec_instr;
  logic [31:0] exec_pc;
  logic        exec_busy = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [3:0]  flags = '0;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arm7_pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .decode_en    (decode_en),
    .decode_instr (decode_instr),
    .exec_en      (exec_en),
    .exec_instr   (exec_instr),
    .exec_pc      (exec_pc),
    .exec_busy    (exec_busy),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .flags        (flags),
    .retired      (retired)
  );

  // Instruction memory image for the random run: condition field varies with address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[5:2] ^ a[9:6], a[29:2] ^ 28'h5A5C3E1};
  endfunction

  // ARM condition table; collapses to "always" when the feature is compiled out.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, pass;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: pass = z;
      4'h1: pass = !z;
      4'h2: pass = cy;
      4'h3: pass = !cy;
      4'h4: pass = n;
      4'h5: pass = !n;
      4'h6: pass = v;
      4'h7: pass = !v;
      4'h8: pass = cy && !z;
      4'h9: pass = !cy || z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return COND_EN ? pass : 1'b1;
  endfunction

  // First address at or after a whose instruction will actually execute.
  function automatic logic [31:0] first_pass(input logic [31:0] a, input logic [3:0] f);
    logic [31:0] p, w;
    p = a;
    for (int i = 0; i < 64; i++) begin
      w = mem_word(p);
      if (ref_cond(w[31:28], f)) return p;
      p = p + 32'd4;
    end
    return p;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; exec_busy = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (decode_en !== 1'b0) begin n_fail++; $display("FAIL reset_decode_en: got %b want 0", decode_en); end
    n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL reset_exec_en: got %b want 0", exec_en); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_checks++; if (exec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_exec_pc: got %h want 0", exec_pc); end
    n_checks++; if (exec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_exec_instr: got %h want 0", exec_instr); end
    n_checks++; if (decode_instr !== 32'h0) begin n_fail++; $display("FAIL reset_decode_instr: got %h want 0", decode_instr); end
    n_checks++; if (retired !== 32'h0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
  endtask

  task automatic test_stream();
    apply_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      imem_rdata = imem_addr;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req c%0d: got %b want 1", k, imem_req); end
      n_checks++; if (imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_addr c%0d: got %h want %h", k, imem_addr, 4 * k); end
      n_checks++; if (exec_en !== (k >= 3)) begin n_fail++; $display("FAIL stream_exec_en c%0d: got %b want %b", k, exec_en, k >= 3); end
      if (k >= 3) begin
        n_checks++; if (exec_pc !== 32'(4 * (k - 3))) begin n_fail++; $display("FAIL stream_exec_pc c%0d: got %h want %h", k, exec_pc, 4 * (k - 3)); end
      end
    end
  endtask

  task automatic test_wait_states();
    int req_cycles = 0, n_dec = 0, n_exec = 0;
    bit done = 1'b0;
    apply_reset();
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (imem_req) req_cycles++;
      imem_ack = imem_req && (req_cycles == 3);
      if (imem_ack) req_cycles = 0;
      imem_rdata = imem_addr;
      if (k < 12) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k / 3))) begin
          n_fail++; $display("FAIL wait_addr c%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 4 * (k / 3)); end
      end
      if (decode_en) begin
        n_checks++; if (decode_instr !== 32'(4 * n_dec)) begin n_fail++; $display("FAIL wait_decode c%0d: got %h want %h", k, decode_instr, 4 * n_dec); end
        n_dec++;
      end
      if (exec_en) begin
        n_checks++; if (exec_pc !== 32'(4 * n_exec)) begin n_fail++; $display("FAIL wait_exec c%0d: got %h want %h", k, exec_pc, 4 * n_exec); end
        n_exec++;
      end
      if (retired == 32'd4) done = 1'b1;
    end
    imem_ack = 1'b0;
    n_checks++; if (!done) begin n_fail++; $display("FAIL wait_timeout: retired=%0d want 4 within 40 cycles", retired); end
    n_checks++; if (n_dec != 4 || n_exec != 4) begin n_fail++; $display("FAIL wait_counts: decodes=%0d execs=%0d want 4 and 4", n_dec, n_exec); end
  endtask

  task automatic test_stall();
    apply_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      exec_busy = (k >= 5 && k <= 7);
      #1;
      imem_rdata = imem_addr;
      if (k >= 5 && k <= 7) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h8) begin n_fail++; $display("FAIL stall_hold c%0d: got en=%b pc=%h want en=1 pc=8", k, exec_en, exec_pc); end
        n_checks++; if (decode_en !== 1'b0) begin n_fail++; $display("FAIL stall_decode c%0d: got %b want 0", k, decode_en); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c%0d: got %b want 0", k, imem_req); end
      end
      if (k == 6) begin
        n_checks++; if (retired !== 32'd2) begin n_fail++; $display("FAIL stall_retired_mid: got %0d want 2", retired); end
      end
      if (k >= 8) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'(8 + 4 * (k - 8))) begin
          n_fail++; $display("FAIL stall_after c%0d: got en=%b pc=%h want en=1 pc=%h", k, exec_en, exec_pc, 8 + 4 * (k - 8)); end
        n_checks++; if (retired !== 32'(2 + (k - 8))) begin n_fail++; $display("FAIL stall_retired c%0d: got %0d want %0d", k, retired, 2 + (k - 8)); end
      end
    end
    exec_busy = 1'b0;
  endtask

  task automatic test_branch();
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      branch_taken  = (k == 3);
      branch_target = 32'h0000_0103;
      imem_ack      = (k < 3) || (k >= 5);
      #1;
      imem_rdata = imem_addr;
      if (k == 3) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
          n_fail++; $display("FAIL branch_setup: got en=%b pc=%h req=%b addr=%h want 1 0 1 c", exec_en, exec_pc, imem_req, imem_addr); end
      end
      if (k == 4 || k == 5) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL branch_drop_hold c%0d: got req=%b addr=%h want 1 c", k, imem_req, imem_addr); end
      end
      if (k == 6) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL branch_refetch: got req=%b addr=%h want 1 100", imem_req, imem_addr); end
      end
      if (k >= 4 && k <= 8) begin
        n_checks++; if (exec_en !== 1'b0) begin n_fail++; $display("FAIL branch_bubble c%0d: got exec_en=%b want 0", k, exec_en); end
      end
      if (k >= 4 && k <= 7) begin
        n_checks++; if (decode_en !== 1'b0) begin n_fail++; $display("FAIL branch_no_decode c%0d: got decode_en=%b instr=%h want 0", k, decode_en, decode_instr); end
      end
      if (k == 8) begin
        n_checks++; if (decode_en !== 1'b1 || decode_instr !== 32'h100) begin n_fail++; $display("FAIL branch_decode: got en=%b instr=%h want 1 100", decode_en, decode_instr); end
      end
      if (k == 9) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h100) begin n_fail++; $display("FAIL branch_exec: got en=%b pc=%h want 1 100", exec_en, exec_pc); end
      end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_cond();
    logic [3:0] c;
    apply_reset();
    flags = 4'b0100;
    imem_ack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      c = (imem_addr == 32'h0) ? 4'h0 : (imem_addr == 32'h4) ? 4'h1 : 4'hE;
      imem_rdata = {c, imem_addr[27:0]};
      if (k == 3) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h0) begin n_fail++; $display("FAIL cond_eq: got en=%b pc=%h want 1 0", exec_en, exec_pc); end
      end
      if (k == 4) begin
        n_checks++; if (exec_pc !== 32'h4 || exec_en !== !COND_EN) begin n_fail++; $display("FAIL cond_ne: got en=%b pc=%h want %b 4", exec_en, exec_pc, !COND_EN); end
      end
      if (k == 5) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h8) begin n_fail++; $display("FAIL cond_next: got en=%b pc=%h want 1 8", exec_en, exec_pc); end
        n_checks++; if (retired !== (COND_EN ? 32'd1 : 32'd2)) begin n_fail++; $display("FAIL cond_retired: got %0d want %0d", retired, COND_EN ? 1 : 2); end
      end
    end
    flags = '0;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      exec_busy = (k >= 4);
      #1;
      imem_rdata = imem_addr;
      if (k == 5) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h4 || retired !== 32'd1) begin
          n_fail++; $display("FAIL rst_stall_setup: got en=%b pc=%h ret=%0d want 1 4 1", exec_en, exec_pc, retired); end
      end
    end
    #2; rst = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b0 || decode_en !== 1'b0 || exec_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_strobes: got req=%b dec=%b exec=%b want 0 0 0", imem_req, decode_en, exec_en); end
    n_checks++; if (retired !== 32'd0 || exec_pc !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_async_state: got ret=%0d pc=%h addr=%h want 0 0 0", retired, exec_pc, imem_addr); end
    exec_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      imem_rdata = imem_addr;
      if (k == 0) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_restart: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
      end
      if (k == 3) begin
        n_checks++; if (exec_en !== 1'b1 || exec_pc !== 32'h0 || retired !== 32'd0) begin
          n_fail++; $display("FAIL rst_first_exec: got en=%b pc=%h ret=%0d want 1 0 0", exec_en, exec_pc, retired); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, want_instr;
    int          model_ret = 0;
    int          wait_left = -1;
    bit          prev_pend = 1'b0;
    apply_reset();
    flags  = 4'($urandom);
    exp_pc = first_pass(32'h0, flags);
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      exec_busy     = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                  : 32'($urandom_range(0, 1023));
      #1;
      if (prev_pend) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_fail++; $display("FAIL rand_handshake c%0d: got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, prev_addr); end
      end
      if (imem_req) begin
        if (wait_left < 0) wait_left = $urandom_range(0, 2);
        imem_ack   = (wait_left == 0);
        imem_rdata = mem_word(imem_addr);
        wait_left  = imem_ack ? -1 : wait_left - 1;
      end else begin
        imem_ack   = ($urandom_range(0, 3) == 0);
        imem_rdata = $urandom;
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      n_checks++; if (retired !== 32'(model_ret)) begin n_fail++; $display("FAIL rand_retired c%0d: got %0d want %0d", k, retired, model_ret); end
      if (exec_en) begin
        want_instr = mem_word(exp_pc);
        n_checks++; if (exec_pc !== exp_pc || exec_instr !== want_instr) begin
          n_fail++; $display("FAIL rand_exec c%0d: got pc=%h instr=%h want pc=%h instr=%h", k, exec_pc, exec_instr, exp_pc, want_instr); end
        if (!exec_busy) begin
          model_ret++;
          exp_pc = branch_taken ? first_pass(branch_target & 32'hFFFF_FFFC, flags) : first_pass(exp_pc + 32'd4, flags);
        end
      end
    end
    exec_busy = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    n_checks++; if (model_ret < 100) begin n_fail++; $display("FAIL rand_progress: got %0d retires want at least 100", model_ret); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_branch();
    test_cond();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
